// File: rtl/softmax_norm_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// softmax_norm_if : input/output streaming handshake bundle for softmax_norm
// Rev 1.0
// ----------------------------------------------------------------------------
interface softmax_norm_if #(
  parameter int DATAWIDTH = 32
);
  logic                 in_valid;
  logic [DATAWIDTH-1:0] in_fp;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATAWIDTH-1:0] out_fp;
  logic [3:0]           out_index;
  logic                 out_last;
  logic                 busy;

  modport slave (
    input  in_valid, in_fp, out_ready,
    output in_ready, out_valid, out_fp, out_index, out_last, busy
  );

  modport master (
    output in_valid, in_fp, out_ready,
    input  in_ready, out_valid, out_fp, out_index, out_last, busy
  );
endinterface
`default_nettype wire

// File: rtl/softmax_norm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// softmax_norm : buffers NUM_CLASSES exp values, sums them, Newton-Raphson 1/sum,
//                then streams out each value scaled by the reciprocal. Rev 1.0
// ----------------------------------------------------------------------------
module softmax_norm #(
  parameter int DATAWIDTH   = 32,
  parameter int NUM_CLASSES = 10,
  parameter int NR_ITER     = 3
) (
  input  logic          clock,
  input  logic          reset,
  softmax_norm_if.slave bus
);
  localparam int                   IDX_W     = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_CLASSES - 1);
  localparam logic [2:0]           LAST_ITER = 3'(NR_ITER - 1);
  localparam logic [DATAWIDTH-1:0] QNAN      = 32'h7FC0_0000;
  localparam logic [DATAWIDTH-1:0] NR_MAGIC  = 32'h7EF3_11C3;
  localparam logic [DATAWIDTH-1:0] FP_TWO    = 32'h4000_0000;

  typedef enum logic [1:0] {S_COLLECT, S_RINIT, S_RITER, S_EMIT} state_t;

  // Round-to-nearest-even multiply; denormals flush to zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    logic [7:0]        ea;
    logic [7:0]        eb;
    logic [47:0]       prod;
    logic [23:0]       m;
    logic              g;
    logic              st;
    logic [24:0]       mr;
    logic signed [9:0] e;
    logic [31:0]       r;
    s    = a[31] ^ b[31];
    ea   = a[30:23];
    eb   = b[30:23];
    prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if (prod[47]) begin
      m  = prod[47:24];
      g  = prod[23];
      st = |prod[22:0];
      e  = e + 10'sd1;
    end else begin
      m  = prod[46:23];
      g  = prod[22];
      st = |prod[21:0];
    end
    mr = {1'b0, m} + 25'(g & (st | m[0]));
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'sd1;
    end
    if (e >= 10'sd255)    r = {s, 8'hFF, 23'd0};
    else if (e <= 10'sd0) r = {s, 31'd0};
    else                  r = {s, e[7:0], mr[22:0]};
    if ((ea == 8'hFF && a[22:0] != 23'd0) || (eb == 8'hFF && b[22:0] != 23'd0)) r = QNAN;
    else if (ea == 8'hFF || eb == 8'hFF) r = (ea == 8'h00 || eb == 8'h00) ? QNAN : {s, 8'hFF, 23'd0};
    else if (ea == 8'h00 || eb == 8'h00) r = {s, 31'd0};
    return r;
  endfunction

  // Round-to-nearest-even add; operands are ordered by magnitude before alignment.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x;
    logic [31:0]       y;
    logic [31:0]       r;
    logic [7:0]        d8;
    logic [49:0]       yw;
    logic [26:0]       mx;
    logic [26:0]       my;
    logic [26:0]       m;
    logic [27:0]       s28;
    logic [24:0]       mr;
    logic signed [9:0] e;
    logic              diff_zero;
    int                lz;
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else                    begin x = b; y = a; end
    d8        = x[30:23] - y[30:23];
    yw        = {1'b1, y[22:0], 26'd0} >> d8;
    mx        = {1'b1, x[22:0], 3'd0};
    my        = {yw[49:24], |yw[23:0]};
    e         = $signed({2'b00, x[30:23]});
    diff_zero = 1'b0;
    if (x[31] == y[31]) begin
      s28 = {1'b0, mx} + {1'b0, my};
      if (s28[27]) begin
        m = {s28[27:2], s28[1] | s28[0]};
        e = e + 10'sd1;
      end else begin
        m = s28[26:0];
      end
    end else begin
      m         = mx - my;
      diff_zero = (m == 27'd0);
      lz        = 27;
      for (int i = 0; i < 27; i++) if (m[i]) lz = 26 - i;
      m = m << lz;
      e = e - 10'(lz);
    end
    mr = {1'b0, m[26:3]} + 25'(m[2] & (m[1] | m[0] | m[3]));
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'sd1;
    end
    if (diff_zero)        r = 32'd0;
    else if (e >= 10'sd255) r = {x[31], 8'hFF, 23'd0};
    else if (e <= 10'sd0) r = {x[31], 31'd0};
    else                  r = {x[31], e[7:0], mr[22:0]};
    if ((a[30:23] == 8'hFF && a[22:0] != 23'd0) || (b[30:23] == 8'hFF && b[22:0] != 23'd0) ||
        (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31])) r = QNAN;
    else if (a[30:23] == 8'hFF) r = a;
    else if (b[30:23] == 8'hFF) r = b;
    else if (x[30:23] == 8'h00) r = 32'd0;
    else if (y[30:23] == 8'h00) r = x;
    return r;
  endfunction

  state_t               state_q,     state_d;
  logic [IDX_W-1:0]     count_q,     count_d;
  logic [DATAWIDTH-1:0] sum_q,       sum_d;
  logic [DATAWIDTH-1:0] y_q,         y_d;
  logic [2:0]           iter_q,      iter_d;
  logic [DATAWIDTH-1:0] recip_q,     recip_d;
  logic                 zero_q,      zero_d;
  logic                 nan_q,       nan_d;
  logic [IDX_W-1:0]     idx_q,       idx_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATAWIDTH-1:0] out_fp_q,    out_fp_d;
  logic [3:0]           out_index_q, out_index_d;
  logic                 out_last_q,  out_last_d;
  logic [DATAWIDTH-1:0] vec_q [NUM_CLASSES];
  logic [DATAWIDTH-1:0] vec_d [NUM_CLASSES];
  logic                 emit_load;
  logic [DATAWIDTH-1:0] y_next;
  logic [DATAWIDTH-1:0] prob;

  // One full Newton-Raphson step: y * (2 - sum*y)
  assign y_next = fp_mul(y_q, fp_add(FP_TWO, fp_mul(sum_q, y_q) ^ 32'h8000_0000));
  assign prob   = nan_q  ? QNAN :
                  zero_q ? '0   : fp_mul(vec_q[idx_q], recip_q);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    sum_d       = sum_q;
    y_d         = y_q;
    iter_d      = iter_q;
    recip_d     = recip_q;
    zero_d      = zero_q;
    nan_d       = nan_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_fp_d    = out_fp_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    vec_d       = vec_q;
    emit_load   = 1'b0;
    case (state_q)
      S_COLLECT: begin
        if (bus.in_valid) begin
          vec_d[count_q] = bus.in_fp;
          sum_d          = fp_add(sum_q, bus.in_fp);
          if (count_q == LAST_IDX) begin
            count_d = '0;
            state_d = S_RINIT;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      S_RINIT: begin
        y_d     = NR_MAGIC - sum_q;
        zero_d  = (sum_q[30:23] == 8'h00);
        nan_d   = (sum_q[30:23] == 8'hFF);
        iter_d  = '0;
        state_d = S_RITER;
      end
      S_RITER: begin
        y_d    = y_next;
        iter_d = iter_q + 1'b1;
        if (iter_q == LAST_ITER) begin
          recip_d = zero_q ? '0 : (nan_q ? QNAN : y_next);
          idx_d   = '0;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        // First EMIT cycle only preloads; afterwards each accept preloads the next element.
        if (!out_valid_q) begin
          emit_load = 1'b1;
        end else if (bus.out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            sum_d       = '0;
            state_d     = S_COLLECT;
          end else begin
            emit_load = 1'b1;
          end
        end
        if (emit_load) begin
          out_valid_d = 1'b1;
          out_fp_d    = prob;
          out_index_d = 4'(idx_q);
          out_last_d  = (idx_q == LAST_IDX);
          idx_d       = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_COLLECT;
      count_q     <= '0;
      sum_q       <= '0;
      y_q         <= '0;
      iter_q      <= '0;
      recip_q     <= '0;
      zero_q      <= 1'b0;
      nan_q       <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_fp_q    <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      y_q         <= y_d;
      iter_q      <= iter_d;
      recip_q     <= recip_d;
      zero_q      <= zero_d;
      nan_q       <= nan_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_fp_q    <= out_fp_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clock) begin
    vec_q <= vec_d;
  end

  assign bus.in_ready  = (state_q == S_COLLECT);
  assign bus.out_valid = out_valid_q;
  assign bus.out_fp    = out_fp_q;
  assign bus.out_index = out_index_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = !((state_q == S_COLLECT) && (count_q == '0));

endmodule
`default_nettype wire

// File: doc/softmax_norm.md
Name: softmax_norm

Overview:
- Downstream of the per-element exponential stage (softmax_fn).
- Collects NUM_CLASSES exp(x) values in IEEE-754 single precision and accumulates their sum.
- Computes 1/sum by Newton-Raphson, then emits each buffered value times 1/sum as the softmax probability vector.
- Uses the codebase's combinational fp_add and fpmul primitives; all sequencing is local to this block.

Parameters:
- datawidth, 32, float width; only 32 is supported.
- NUM_CLASSES, 10, vector length (2..16).
- NR_ITER, 3, Newton-Raphson iterations for the reciprocal (1..4).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_fp holds a valid exp value.
- in_fp  input  datawidth  exp(x) from upstream; softmax_fn drives it on negedge, so it is stable at posedge.
- in_ready  output  1  block accepts input this cycle.
- out_valid  output  1  out_fp/out_index are valid.
- out_ready  input  1  consumer accepts output.
- out_fp  output  datawidth  probability = buf[out_index] * recip.
- out_index  output  4  class index 0..NUM_CLASSES-1.
- out_last  output  1  high with the final element of a vector.
- busy  output  1  high in any state except COLLECT with count==0.

Behaviour:
- Reset (reset=0, asynchronous): state=COLLECT, count=0, sum=0, recip=0. Outputs: in_ready=1, out_valid=0, out_fp=0, out_index=0, out_last=0, busy=0. The buffer contents are don't-care. Reset mid-vector discards all partial data.
- COLLECT:
  - in_ready=1.
  - On posedge with in_valid=1: buf[count]<=in_fp, sum<=fp_add(sum,in_fp), count<=count+1.
  - If count==NUM_CLASSES-1 at that edge: go to RINIT and set count<=0.
- RINIT (1 cycle):
  - in_ready=0.
  - Seed y<= 32'h7EF311C3 - sum, as integer subtraction on the bit pattern.
  - Set iter<=0 and go to RITER.
- RITER (NR_ITER cycles):
  - y<=fpmul(y, fp_add(2.0, -fpmul(sum,y))). The negation is a sign-bit flip. This is one combinational chain per cycle.
  - When iter==NR_ITER-1: recip<=the updated y, go to EMIT.
- Special sums, checked at RINIT and overriding the Newton-Raphson result:
  - Exponent field 0 (zero or denormal): recip forced to 0, so every out_fp is 0.
  - Exponent field 255 (inf or NaN): every out_fp is 32'h7FC00000.
- EMIT:
  - out_valid=1, out_fp=fpmul(buf[idx],recip) registered, out_index=idx, out_last=(idx==NUM_CLASSES-1).
  - out_fp/out_index are held stable while out_valid=1 and out_ready=0.
  - On posedge with out_ready=1: advance idx.
  - After the last element is accepted: out_valid<=0, state=COLLECT, sum<=0.
- Latency: last input accepted at edge T → first out_valid=1 at edge T+NR_ITER+2. With out_ready tied high, a vector takes NUM_CLASSES + NR_ITER + 2 + NUM_CLASSES cycles.
- in_valid outside COLLECT is ignored; in_ready=0 there, and no data is lost by this block.
- Accuracy: with NR_ITER=3, outputs are within ±4 ulp of the correctly rounded exp_i/sum for sums in [1, 1e6].
- Back-to-back vectors: the next in_valid is accepted on the edge after out_last is handshaked.

Test Plan:
1. Parameters NUM_CLASSES=10, NR_ITER=3. Ten inputs of 32'h3F800000 (1.0) with out_ready=1 → out_valid rises 5 edges after the 10th accept. Ten outputs of 32'h3DCCCCCD ±4 ulp, out_index 0..9, out_last only on index 9.
2. NUM_CLASSES=4, inputs 1.0, 2.0, 3.0, 4.0 → outputs ≈ 32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3E99999A, 32'h3ECCCCCD (0.1/0.2/0.3/0.4) ±4 ulp.
3. Backpressure: hold out_ready=0 for 7 cycles on index 2 → out_fp/out_index stay stable, no index is skipped, all elements are delivered in order.
4. in_valid held high through RINIT/RITER/EMIT with a changing in_fp → in_ready=0, the extra words are not consumed, and the outputs match scenario 1.
5. Assert reset low asynchronously (mid-clock) during EMIT at index 5 → immediate out_valid=0, in_ready=1, busy=0. A following clean vector yields the correct results.
6. All inputs 0 → all outputs 0. A single +inf input (32'h7F800000) → all outputs 32'h7FC00000.
